// File: rtl/sig_stim_gen_pkg.sv
// Shared types and constants for the sig_stim_gen stimulus transmitter.
package sig_stim_pkg;

  // Waveform selects; codes 6 and 7 are reserved and produce zero samples.
  typedef enum logic [2:0] {
    MODE_IMP  = 3'd0,
    MODE_STEP = 3'd1,
    MODE_RAMP = 3'd2,
    MODE_SQR  = 3'd3,
    MODE_PRBS = 3'd4,
    MODE_NYQ  = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // 15-bit Fibonacci LFSR, x^15 + x^14 + 1.
  localparam int LFSR_LEN   = 15;
  localparam int LFSR_TAP_A = 14;
  localparam int LFSR_TAP_B = 13;

  // Largest positive code of a w-bit signed sample.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Symmetric negative full scale; the most-negative code is avoided.
  function automatic int sat_nmax(input int w);
    return -sat_max(w);
  endfunction

endpackage

// File: rtl/sig_stim_gen_if.sv
// Control/status and sample-stream bundle of sig_stim_gen.
// master: the generator; slave: the host controller and the filter input.
interface sig_stim_gen_if #(
  parameter int gp_data_width = 16,
  parameter int gp_cnt_width  = 16
);
  logic                     i_ena;
  logic                     i_start;
  logic                     i_abort;
  logic [2:0]               i_mode;
  logic [gp_cnt_width-1:0]  i_nr_samples;
  logic [gp_data_width-1:0] o_data;
  logic                     o_valid;
  logic                     o_busy;
  logic                     o_done;

  modport master (
    input  i_ena, i_start, i_abort, i_mode, i_nr_samples,
    output o_data, o_valid, o_busy, o_done
  );

  modport slave (
    output i_ena, i_start, i_abort, i_mode, i_nr_samples,
    input  o_data, o_valid, o_busy, o_done
  );
endinterface

// File: rtl/sig_stim_gen_lfsr15.sv
// 15-bit PRBS generator: reloads the seed on load, steps once per advance.
module sig_lfsr15
  import sig_stim_pkg::*;
#(
  parameter logic [LFSR_LEN-1:0] gp_seed = 15'h0001
) (
  input  logic                i_clk,
  input  logic                i_rst_an,
  input  logic                i_load,
  input  logic                i_adv,
  output logic [LFSR_LEN-1:0] o_state
);

  // Shift register: seed on reset/load, shift in the feedback on advance.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      o_state <= gp_seed;
    end else if (i_load) begin
      o_state <= gp_seed;
    end else if (i_adv) begin
      o_state <= {o_state[LFSR_LEN-2:0], o_state[LFSR_TAP_A] ^ o_state[LFSR_TAP_B]};
    end
  end

endmodule

// File: rtl/sig_stim_gen.sv
// Burst stimulus generator feeding the filt_* sample input (data + enable).
module sig_stim_gen
  import sig_stim_pkg::*;
#(
  parameter int                  gp_data_width   = 16,
  parameter int                  gp_cnt_width    = 16,
  parameter int                  gp_sq_half_log2 = 3,
  parameter logic [LFSR_LEN-1:0] gp_lfsr_seed    = 15'h0001
) (
  input  logic           i_clk,
  input  logic           i_rst_an,
  sig_stim_gen_if.master bus
);

  localparam int DW  = gp_data_width;
  localparam int CW  = gp_cnt_width;
  localparam int SQW = gp_sq_half_log2 + 1;

  localparam logic [DW-1:0] MAX_CODE  = DW'(sat_max(DW));
  localparam logic [DW-1:0] NMAX_CODE = DW'(sat_nmax(DW));
  localparam logic [LFSR_LEN-1:0] LFSR_OUT_MASK = LFSR_LEN'(1);

  state_e            state_q, state_d;
  logic [2:0]        mode_q;
  logic [CW-1:0]     nr_q;
  logic [CW-1:0]     cnt_q;
  logic [DW-1:0]     ramp_q;
  logic [SQW-1:0]    sq_phase_q;
  logic [LFSR_LEN-1:0] lfsr_state;
  logic              gen_load;
  logic              gen_adv;
  logic [DW-1:0]     sample_d;
  logic [DW-1:0]     data_q;
  logic              valid_q;
  logic              done_q;
  logic              prbs_pos;

  sig_lfsr15 #(.gp_seed(gp_lfsr_seed)) u_lfsr (
    .i_clk    (i_clk),
    .i_rst_an (i_rst_an),
    .i_load   (gen_load),
    .i_adv    (gen_adv),
    .o_state  (lfsr_state)
  );

  assign prbs_pos = (lfsr_state & LFSR_OUT_MASK) != '0;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next state plus generator load/advance strobes; abort outranks everything.
  // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d  = state_q;
    gen_load = 1'b0;
    gen_adv  = 1'b0;
    if (bus.i_abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            gen_load = 1'b1;
            state_d  = (bus.i_nr_samples == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.i_ena) begin
            gen_adv = 1'b1;
            if (cnt_q == nr_q - CW'(1)) state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Waveform select for the sample about to be registered (index n = cnt_q).
  always_comb begin
    sample_d = '0;
    case (mode_q)
      MODE_IMP:  sample_d = (cnt_q == '0) ? MAX_CODE : '0;
      MODE_STEP: sample_d = MAX_CODE;
      MODE_RAMP: sample_d = ramp_q;
      MODE_SQR:  sample_d = sq_phase_q[SQW-1] ? NMAX_CODE : MAX_CODE;
      MODE_PRBS: sample_d = prbs_pos ? MAX_CODE : NMAX_CODE;
      MODE_NYQ:  sample_d = cnt_q[0] ? NMAX_CODE : MAX_CODE;
      default:   sample_d = '0;
    endcase
  end

  // Burst parameters, generator state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      mode_q     <= '0;
      nr_q       <= '0;
      cnt_q      <= '0;
      ramp_q     <= '0;
      sq_phase_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (gen_load) begin
        mode_q     <= bus.i_mode;
        nr_q       <= bus.i_nr_samples;
        cnt_q      <= '0;
        ramp_q     <= '0;
        sq_phase_q <= '0;
      end else if (gen_adv) begin
        cnt_q      <= cnt_q + CW'(1);
        ramp_q     <= ramp_q + DW'(1);
        sq_phase_q <= sq_phase_q + SQW'(1);
      end
      valid_q <= gen_adv;
      data_q  <= gen_adv ? sample_d : '0;
      // Done trails the DONE state by one edge so it follows the last sample.
      done_q  <= (state_q == ST_DONE) && !bus.i_abort;
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = (state_q == ST_RUN);
  assign bus.o_done  = done_q;

endmodule

// File: tb/tb_sig_stim_gen.sv
// Directed bench for sig_stim_gen (W=16, P=1, seed 1).
module tb_sig_stim_gen;

  localparam logic [15:0] MAXV  = 16'h7FFF;  //  32767
  localparam logic [15:0] NMAXV = 16'h8001;  // -32767

  logic i_clk;
  logic i_rst_an;
  int   n_pass;
  int   n_total;

  sig_stim_gen_if #(.gp_data_width(16), .gp_cnt_width(16)) bus ();

  sig_stim_gen #(
    .gp_data_width   (16),
    .gp_cnt_width    (16),
    .gp_sq_half_log2 (1),
    .gp_lfsr_seed    (15'h0001)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_an (i_rst_an),
    .bus      (bus.master)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic start_burst(input logic [2:0] mode, input logic [15:0] n);
    @(negedge i_clk);
    bus.i_start      = 1'b1;
    bus.i_mode       = mode;
    bus.i_nr_samples = n;
    @(negedge i_clk);
    bus.i_start      = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_total++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== 16'h0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0)
      $display("FAIL reset_outputs: got v=%b d=%h b=%b dn=%b, required all 0",
               bus.o_valid, bus.o_data, bus.o_busy, bus.o_done);
    else n_pass++;
    @(negedge i_clk);
    i_rst_an = 1'b1;
    repeat (2) @(negedge i_clk);
    n_total++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0)
      $display("FAIL reset_idle: got v=%b b=%b, required 0 0", bus.o_valid, bus.o_busy);
    else n_pass++;
  endtask

  task automatic test_impulse();
    logic [15:0] exp [4] = '{MAXV, 16'h0, 16'h0, 16'h0};
    start_burst(3'd0, 16'd4);
    n_total++;
    if (bus.o_busy !== 1'b1 || bus.o_valid !== 1'b0)
      $display("FAIL imp_latency: got b=%b v=%b, required b=1 v=0", bus.o_busy, bus.o_valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      n_total++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== exp[i] || bus.o_done !== 1'b0)
        $display("FAIL imp_sample[%0d]: got v=%b d=%0d dn=%b, required v=1 d=%0d dn=0",
                 i, bus.o_valid, $signed(bus.o_data), bus.o_done, $signed(exp[i]));
      else n_pass++;
    end
    @(negedge i_clk);
    n_total++;
    if (bus.o_done !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_data !== 16'h0 || bus.o_busy !== 1'b0)
      $display("FAIL imp_done: got dn=%b v=%b d=%h b=%b, required dn=1 v=0 d=0 b=0",
               bus.o_done, bus.o_valid, bus.o_data, bus.o_busy);
    else n_pass++;
    @(negedge i_clk);
    n_total++;
    if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0)
      $display("FAIL imp_done_pulse: got dn=%b b=%b, required 0 0", bus.o_done, bus.o_busy);
    else n_pass++;
  endtask

  task automatic test_ramp_stall();
    // Per-negedge expectation: valid flag and data; two stall cycles after sample 2.
    logic        ev [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] ed [7] = '{16'd0, 16'd1, 16'd2, 16'd0, 16'd0, 16'd3, 16'd4};
    int n_valid = 0;
    start_burst(3'd2, 16'd5);
    for (int i = 0; i < 7; i++) begin
      @(negedge i_clk);
      n_total++;
      if (bus.o_valid !== ev[i] || bus.o_data !== ed[i])
        $display("FAIL ramp[%0d]: got v=%b d=%0d, required v=%b d=%0d",
                 i, bus.o_valid, bus.o_data, ev[i], ed[i]);
      else n_pass++;
      if (bus.o_valid === 1'b1) n_valid++;
      bus.i_ena = (i == 2 || i == 3) ? 1'b0 : 1'b1;
    end
    repeat (3) begin
      @(negedge i_clk);
      if (bus.o_valid === 1'b1) n_valid++;
    end
    n_total++;
    if (n_valid != 5) $display("FAIL ramp_count: got %0d valid samples, required 5", n_valid);
    else n_pass++;
  endtask

  task automatic test_square();
    logic [15:0] exp [6] = '{MAXV, MAXV, NMAXV, NMAXV, MAXV, MAXV};
    start_burst(3'd3, 16'd6);
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      n_total++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== exp[i])
        $display("FAIL sqr[%0d]: got v=%b d=%0d, required v=1 d=%0d",
                 i, bus.o_valid, $signed(bus.o_data), $signed(exp[i]));
      else n_pass++;
    end
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_prbs();
    // States: 0x0001, 0x0002..0x2000 (13), 0x4001, 0x0003, 0x0006.
    logic [15:0] exp [17];
    exp[0] = MAXV;
    for (int i = 1; i <= 13; i++) exp[i] = NMAXV;
    exp[14] = MAXV;
    exp[15] = MAXV;
    exp[16] = NMAXV;
    start_burst(3'd4, 16'd17);
    for (int i = 0; i < 17; i++) begin
      @(negedge i_clk);
      n_total++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== exp[i])
        $display("FAIL prbs[%0d]: got v=%b d=%0d, required v=1 d=%0d",
                 i, bus.o_valid, $signed(bus.o_data), $signed(exp[i]));
      else n_pass++;
    end
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_nyq_reserved();
    logic [15:0] exp [3] = '{MAXV, NMAXV, MAXV};
    start_burst(3'd5, 16'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      n_total++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== exp[i])
        $display("FAIL nyq[%0d]: got v=%b d=%0d, required v=1 d=%0d",
                 i, bus.o_valid, $signed(bus.o_data), $signed(exp[i]));
      else n_pass++;
    end
    repeat (2) @(negedge i_clk);
    start_burst(3'd6, 16'd2);
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      n_total++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== 16'h0)
        $display("FAIL reserved[%0d]: got v=%b d=%h, required v=1 d=0", i, bus.o_valid, bus.o_data);
      else n_pass++;
    end
    @(negedge i_clk);
    n_total++;
    if (bus.o_done !== 1'b1)
      $display("FAIL reserved_done: got dn=%b, required 1", bus.o_done);
    else n_pass++;
    @(negedge i_clk);
  endtask

  task automatic test_async_reset();
    start_burst(3'd2, 16'd10);
    repeat (3) @(negedge i_clk);
    #2 i_rst_an = 1'b0;
    #1;
    n_total++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== 16'h0 || bus.o_busy !== 1'b0)
      $display("FAIL async_reset: got v=%b d=%h b=%b, required 0 0 0",
               bus.o_valid, bus.o_data, bus.o_busy);
    else n_pass++;
    @(negedge i_clk);
    i_rst_an = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      n_total++;
      if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0)
        $display("FAIL post_reset_idle[%0d]: got v=%b b=%b dn=%b, required 0 0 0",
                 i, bus.o_valid, bus.o_busy, bus.o_done);
      else n_pass++;
    end
  endtask

  task automatic test_zero_len();
    start_burst(3'd1, 16'd0);
    n_total++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0)
      $display("FAIL zero_len_first: got v=%b b=%b dn=%b, required 0 0 0",
               bus.o_valid, bus.o_busy, bus.o_done);
    else n_pass++;
    @(negedge i_clk);
    n_total++;
    if (bus.o_valid !== 1'b0 || bus.o_done !== 1'b1)
      $display("FAIL zero_len_done: got v=%b dn=%b, required v=0 dn=1", bus.o_valid, bus.o_done);
    else n_pass++;
    @(negedge i_clk);
    n_total++;
    if (bus.o_done !== 1'b0)
      $display("FAIL zero_len_pulse: got dn=%b, required 0", bus.o_done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n_valid = 0;
    int n_done  = 0;
    start_burst(3'd1, 16'd3);
    @(negedge i_clk);
    if (bus.o_valid === 1'b1) n_valid++;
    // A new start during the run must neither restart nor change the mode.
    bus.i_start      = 1'b1;
    bus.i_mode       = 3'd0;
    bus.i_nr_samples = 16'd10;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      bus.i_start = 1'b0;
      if (bus.o_valid === 1'b1) begin
        n_valid++;
        n_total++;
        if (bus.o_data !== MAXV)
          $display("FAIL start_ignored_data: got %0d, required %0d", $signed(bus.o_data), $signed(MAXV));
        else n_pass++;
      end
      if (bus.o_done === 1'b1) n_done++;
    end
    n_total++;
    if (n_valid != 3 || n_done != 1)
      $display("FAIL start_ignored_count: got %0d samples %0d done, required 3 and 1", n_valid, n_done);
    else n_pass++;
  endtask

  task automatic test_abort();
    int n_bad = 0;
    start_burst(3'd1, 16'd8);
    repeat (2) @(negedge i_clk);
    bus.i_abort = 1'b1;
    @(negedge i_clk);
    bus.i_abort = 1'b0;
    n_total++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== 16'h0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0)
      $display("FAIL abort_idle: got v=%b d=%h b=%b dn=%b, required 0 0 0 0",
               bus.o_valid, bus.o_data, bus.o_busy, bus.o_done);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      if (bus.o_valid !== 1'b0 || bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) n_bad++;
    end
    n_total++;
    if (n_bad != 0)
      $display("FAIL abort_quiet: got %0d active cycles after abort, required 0", n_bad);
    else n_pass++;
  endtask

  initial begin
    n_pass           = 0;
    n_total          = 0;
    i_rst_an         = 1'b0;
    bus.i_ena        = 1'b1;
    bus.i_start      = 1'b0;
    bus.i_abort      = 1'b0;
    bus.i_mode       = 3'd0;
    bus.i_nr_samples = 16'd0;
    test_reset();
    test_impulse();
    test_ramp_stall();
    test_square();
    test_prbs();
    test_nyq_reserved();
    test_async_reset();
    test_zero_len();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
